// File: rtl/adc_sample_packer.sv
// adc_sample_packer: packs ADC frames into a dense MSB-first bit stream of memory words
//   adc_clkinp            clock, rising edge
//   iStateResetN          asynchronous active-low reset
//   iSampleValid/iSamples one frame per strobe, channel 0 in the MSBs
//   iSystemTrig           capture start on rising edge (IDLE/DONE only)
//   iRecLength            frames per record, latched on the trigger edge
//   iAbort                synchronous abort back to IDLE
//   oWREN/oWAddr/oADCData/oBYTEEN  memory write port
//   oBusy/oDataReady/oOverflow     record status
// Build option ADC_PACK_TESTPAT_EN: replace iSamples with a per-channel ramp pattern.
module adc_sample_packer #(
  parameter int N_CH = 8,
  parameter int SAMPLE_W = 12,
  parameter int MEM_W = 128,
  parameter int ADDR_W = 14
) (
  input  logic                     adc_clkinp,
  input  logic                     iStateResetN,
  input  logic                     iSampleValid,
  input  logic [N_CH*SAMPLE_W-1:0] iSamples,
  input  logic                     iSystemTrig,
  input  logic [15:0]              iRecLength,
  input  logic                     iAbort,
  output logic                     oWREN,
  output logic [ADDR_W-1:0]        oWAddr,
  output logic [MEM_W-1:0]         oADCData,
  output logic [MEM_W/8-1:0]       oBYTEEN,
  output logic                     oBusy,
  output logic                     oDataReady,
  output logic                     oOverflow
);
  localparam int FW = N_CH * SAMPLE_W;
  localparam int ACC_W = MEM_W + FW;
  localparam int CW = $clog2(ACC_W + 1);
  localparam int NB = MEM_W / 8;
  localparam logic [CW-1:0] MW = CW'(MEM_W);
  localparam logic [CW-1:0] FWC = CW'(FW);
  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, DONE} state_t;
  state_t state;
  logic trig_q, trig_edge, last, full;
  logic [15:0] len, fcnt;
  logic [ACC_W-1:0] acc, cat, rest;
  logic [CW-1:0] abits, nbits, rem, tail_bytes;
  logic [ADDR_W:0] waddr;
  logic [FW-1:0] frame;
  logic [MEM_W-1:0] word, tail;
  logic [NB-1:0] tail_be;
`ifdef ADC_PACK_TESTPAT_EN
  always_comb begin
    frame = '0;
    for (int c = 0; c < N_CH; c++)
      frame[FW-1-c*SAMPLE_W -: SAMPLE_W] = SAMPLE_W'(32'(fcnt) * N_CH + c);
  end
`else
  assign frame = iSamples;
`endif
  // acc holds abits residual stream bits right-aligned, always fewer than MEM_W
  // outside CAPTURE; a new frame is appended below them and the oldest MEM_W
  // bits are peeled off the top once enough have accumulated.
  always_comb begin
    trig_edge = iSystemTrig & ~trig_q;
    last = (fcnt + 16'd1) == len;
    cat = (acc << FW) | ACC_W'(frame);
    nbits = abits + FWC;
    full = nbits >= MW;
    rem = nbits - MW;
    word = MEM_W'(cat >> rem);
    rest = cat & ~({ACC_W{1'b1}} << rem);
    tail = MEM_W'(acc) << (MW - abits);
    tail_bytes = (abits + CW'(7)) >> 3;
    tail_be = ~({NB{1'b1}} >> tail_bytes);
  end
  // waddr carries one extra bit so running past the last address is visible
  // as waddr[ADDR_W] instead of wrapping.
  always_ff @(posedge adc_clkinp or negedge iStateResetN)
    if (!iStateResetN) begin
      state <= IDLE;
      trig_q <= 1'b1;
      len <= '0;
      fcnt <= '0;
      acc <= '0;
      abits <= '0;
      waddr <= '0;
      oWREN <= 1'b0;
      oWAddr <= '0;
      oADCData <= '0;
      oBYTEEN <= '0;
      oBusy <= 1'b0;
      oDataReady <= 1'b0;
      oOverflow <= 1'b0;
    end else begin
      trig_q <= iSystemTrig;
      oWREN <= 1'b0;
      oBYTEEN <= '0;
      if (iAbort) begin
        state <= IDLE;
        acc <= '0;
        abits <= '0;
        oBusy <= 1'b0;
        oDataReady <= 1'b0;
        oOverflow <= 1'b0;
      end else case (state)
        IDLE, DONE: if (trig_edge) begin
          len <= iRecLength;
          fcnt <= '0;
          acc <= '0;
          abits <= '0;
          waddr <= '0;
          oWAddr <= '0;
          oDataReady <= 1'b0;
          oOverflow <= 1'b0;
          oBusy <= 1'b1;
          state <= (iRecLength == 16'd0) ? FLUSH : CAPTURE;
        end
        CAPTURE: if (iSampleValid) begin
          fcnt <= fcnt + 16'd1;
          if (last) state <= FLUSH;
          if (!full) begin
            acc <= cat;
            abits <= nbits;
          end else if (waddr[ADDR_W]) begin
            state <= DONE;
            oBusy <= 1'b0;
            oDataReady <= 1'b1;
            oOverflow <= 1'b1;
          end else begin
            oWREN <= 1'b1;
            oBYTEEN <= '1;
            oADCData <= word;
            oWAddr <= waddr[ADDR_W-1:0];
            waddr <= waddr + 1'b1;
            acc <= rest;
            abits <= rem;
          end
        end
        FLUSH: begin
          state <= DONE;
          oBusy <= 1'b0;
          oDataReady <= 1'b1;
          acc <= '0;
          abits <= '0;
          if (abits != '0) begin
            if (waddr[ADDR_W]) oOverflow <= 1'b1;
            else begin
              oWREN <= 1'b1;
              oBYTEEN <= tail_be;
              oADCData <= tail;
              oWAddr <= waddr[ADDR_W-1:0];
              waddr <= waddr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_adc_sample_packer.sv
// tb_adc_sample_packer: random frames against a bit-stream reference model, two address widths
module tb_adc_sample_packer;
  localparam int N_CH = 8, SW = 12, FW = 96, MW = 128;
  typedef struct {int c; int a; logic [127:0] d; logic [15:0] b;} wr_t;
  logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0, trig = 1'b1, abort = 1'b0;
  logic [FW-1:0] samples = '0;
  logic [15:0] rec_len = '0;
  logic wren_a, busy_a, rdy_a, ovf_a, wren_b, busy_b, rdy_b, ovf_b;
  logic [13:0] waddr_a;
  logic [1:0] waddr_b;
  logic [127:0] data_a, data_b;
  logic [15:0] be_a, be_b;
  int n_chk = 0, n_fail = 0, ncyc = 0, tcyc = 1 << 30, dc0 = -1, dc1 = -1;
  wr_t wq0[$], wq1[$];
  logic [FW-1:0] fq[$];
  int vq[$];
  adc_sample_packer dut_a (
    .adc_clkinp(clk), .iStateResetN(rst_n), .iSampleValid(valid), .iSamples(samples),
    .iSystemTrig(trig), .iRecLength(rec_len), .iAbort(abort), .oWREN(wren_a), .oWAddr(waddr_a),
    .oADCData(data_a), .oBYTEEN(be_a), .oBusy(busy_a), .oDataReady(rdy_a), .oOverflow(ovf_a)
  );
  adc_sample_packer #(.ADDR_W(2)) dut_b (
    .adc_clkinp(clk), .iStateResetN(rst_n), .iSampleValid(valid), .iSamples(samples),
    .iSystemTrig(trig), .iRecLength(rec_len), .iAbort(abort), .oWREN(wren_b), .oWAddr(waddr_b),
    .oADCData(data_b), .oBYTEEN(be_b), .oBusy(busy_b), .oDataReady(rdy_b), .oOverflow(ovf_b)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    ncyc++;
    if (wren_a) wq0.push_back('{ncyc, int'(waddr_a), data_a, be_a});
    else check("a_idle_be", be_a, 0);
    if (wren_b) wq1.push_back('{ncyc, int'(waddr_b), data_b, be_b});
    else check("b_idle_be", be_b, 0);
    if (rdy_a && dc0 < 0 && ncyc > tcyc) dc0 = ncyc;
    if (rdy_b && dc1 < 0 && ncyc > tcyc) dc1 = ncyc;
  end
  function automatic logic [FW-1:0] frame_model(input int i);
    logic [FW-1:0] f;
`ifdef ADC_PACK_TESTPAT_EN
    for (int c = 0; c < N_CH; c++) f[FW-1-c*SW -: SW] = SW'(i * N_CH + c);
`else
    f = fq[i];
`endif
    return f;
  endfunction
  task automatic verify(input int id, input int aw, input int len);
    wr_t q[$];
    bit s[$];
    logic [FW-1:0] f;
    logic [127:0] d;
    logic [15:0] b;
    logic ovf;
    int total, nw, nexp, edc, dc, e, nb, ec;
    string p;
    p = id ? "b_" : "a_";
    if (id == 0) begin q = wq0; dc = dc0; ovf = ovf_a; end
    else begin q = wq1; dc = dc1; ovf = ovf_b; end
    for (int i = 0; i < len; i++) begin
      f = frame_model(i);
      for (int k = FW - 1; k >= 0; k--) s.push_back(f[k]);
    end
    total = len * FW;
    nw = (total + MW - 1) / MW;
    nexp = nw > (1 << aw) ? (1 << aw) : nw;
    edc = len == 0 ? tcyc + 2 : vq[len-1] + 2;
    if (nw > nexp) begin
      e = (nexp + 1) * MW;
      edc = e > total ? vq[len-1] + 2 : vq[(e-1)/FW] + 1;
    end
    check({p, "num_writes"}, q.size(), nexp);
    for (int i = 0; i < q.size() && i < nexp; i++) begin
      for (int k = 0; k < MW; k++) d[MW-1-k] = (i * MW + k < total) ? s[i*MW+k] : 1'b0;
      nb = (total - i * MW >= MW) ? 16 : (total - i * MW + 7) / 8;
      b = ~(16'hFFFF >> nb);
      ec = ((i + 1) * MW <= total) ? vq[((i+1)*MW-1)/FW] + 1 : vq[len-1] + 2;
      check({p, "addr"}, q[i].a, i);
      check({p, "data"}, q[i].d, d);
      check({p, "byteen"}, q[i].b, b);
      check({p, "write_cycle"}, q[i].c, ec);
    end
    check({p, "done_cycle"}, dc, edc);
    check({p, "overflow"}, ovf, nw > nexp);
  endtask
  task automatic send(input logic [FW-1:0] x, input bit t);
    @(posedge clk); #1;
    valid = 1'b1;
    samples = x;
    if (t) trig = 1'b1;
    fq.push_back(x);
    vq.push_back(ncyc + 1);
    @(posedge clk); #1;
    valid = 1'b0;
  endtask
  task automatic start(input int len);
    trig = 1'b0;
    rec_len = 16'(len);
    @(posedge clk); #1;
    wq0.delete(); wq1.delete(); fq.delete(); vq.delete();
    dc0 = -1;
    dc1 = -1;
    trig = 1'b1;
    tcyc = ncyc + 1;
    @(posedge clk); #1;
    trig = 1'b0;
  endtask
  task automatic run(input int len, input int gmax, input int extra, input bit retrig);
    start(len);
    for (int i = 0; i < len + extra; i++) begin
      repeat ($urandom_range(gmax)) @(posedge clk);
      send({$urandom, $urandom, $urandom}, retrig && i == 1);
    end
    #1 trig = 1'b0;
    for (int w = 0; w < 60 && (dc0 < 0 || dc1 < 0); w++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    verify(0, 14, len);
    verify(1, 2, len);
  endtask
  initial begin
    #12;
    check("rst_wren", {wren_a, wren_b}, 0);
    check("rst_status", {busy_a, rdy_a, ovf_a, busy_b, rdy_b, ovf_b}, 0);
    check("rst_data", data_a, 0);
    check("rst_addr", waddr_a, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("held_trig_busy", {busy_a, busy_b}, 0);
    run(4, 0, 0, 0);
    run(1, 2, 1, 0);
    run(0, 0, 1, 0);
    run(8, 1, 0, 1);
    start(10);
    send({$urandom, $urandom, $urandom}, 1'b0);
    send({$urandom, $urandom, $urandom}, 1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_status", {busy_a, rdy_a, wren_a, busy_b, rdy_b, wren_b}, 0);
    check("pre_abort_writes", wq0.size(), 1);
    for (int i = 0; i < 3; i++) send({$urandom, $urandom, $urandom}, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("post_abort_writes_a", wq0.size(), 1);
    check("post_abort_writes_b", wq1.size(), 1);
    check("post_abort_busy", {busy_a, busy_b}, 0);
    run(3, 1, 0, 0);
    for (int r = 0; r < 12; r++)
      run($urandom_range(12), $urandom_range(3), $urandom_range(2), 1'($urandom_range(1)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
